// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared constants for the BIST vector sequencer
package bist_pkg;

    // Sequencer FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Result reporting modes
    localparam logic BIST_MODE_CMP = 1'b0;
    localparam logic BIST_MODE_SIG = 1'b1;

    // JTAG instruction opcodes that reach this block
    localparam logic [3:0] RUNBIST = 4'h4;
    localparam logic [3:0] GETTEST = 4'h5;

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - multiple-input signature register for response compaction
module bist_misr #(
    parameter int                RESP_W = 4,
    parameter logic [RESP_W-1:0] TAPS   = 4'b1001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [RESP_W-1:0] data_in,
    output logic [RESP_W-1:0] sig_out
);

    logic [RESP_W-1:0] misr;

    // Shift left, feed the tap parity into bit 0, then fold in the new response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr <= '0;
        end else if (clear) begin
            misr <= '0;
        end else if (enable) begin
            misr <= {misr[RESP_W-2:0], ^(misr & TAPS)} ^ data_in;
        end
    end

    assign sig_out = misr;

endmodule

// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - stored-vector BIST engine with compare and MISR signature modes
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int                DEPTH  = 256,
    parameter int                STIM_W = 5,
    parameter int                RESP_W = 4,
    parameter int                LAT    = 1,
    parameter logic [RESP_W-1:0] TAPS   = 4'b1001,
    parameter int                AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_clear,
    input  logic                     load_valid,
    input  logic [STIM_W+RESP_W-1:0] load_data,
    output logic                     load_full,
    output logic [AW:0]              entries,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mode,
    input  logic [RESP_W-1:0]        golden_sig,
    output logic [STIM_W-1:0]        dut_stim,
    input  logic [RESP_W-1:0]        dut_resp,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [AW:0]              err_count,
    output logic [AW-1:0]            first_fail,
    output logic [RESP_W-1:0]        signature
);

    localparam int VW  = STIM_W + RESP_W;
    localparam int DCW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    logic [1:0]        state;
    logic [VW-1:0]     mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW-1:0]     rd_idx;
    logic [VW-1:0]     rd_word;
    logic              mode_q;
    logic [RESP_W-1:0] golden_q;
    logic [DCW-1:0]    drain_cnt;

    // Response pipeline: one slot per edge between stimulus update and sampling
    logic [LAT-1:0]    pipe_vld;
    logic [AW-1:0]     pipe_idx [LAT];
    logic [RESP_W-1:0] pipe_exp [LAT];

    logic start_run;
    logic last_apply;
    logic drain_end;
    logic sample_v;
    logic mismatch;
    logic load_we;

    assign entries    = wr_ptr;
    assign load_full  = (wr_ptr == (AW+1)'(DEPTH));
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign rd_word    = mem[rd_idx];

    assign start_run  = (state == ST_IDLE) && start && !abort;
    assign last_apply = (state == ST_APPLY) && ({1'b0, rd_idx} == entries - (AW+1)'(1));
    assign drain_end  = (state == ST_DRAIN) && (drain_cnt == DCW'(LAT));
    assign sample_v   = pipe_vld[LAT-1] && busy && !abort;
    assign mismatch   = (dut_resp != pipe_exp[LAT-1]);
    assign load_we    = !busy && !load_clear && load_valid && !load_full;

    // Write pointer: clear wins over a write; both frozen while a run is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (!busy) begin
            if (load_clear) begin
                wr_ptr <= '0;
            end else if (load_valid && !load_full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
        end
    end

    // Vector storage, no reset: contents are only meaningful below the write pointer
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[wr_ptr[AW-1:0]] <= load_data;
        end
    end

    // Run control FSM: apply N vectors, then wait LAT+1 edges for the tail samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_idx    <= '0;
            drain_cnt <= '0;
            mode_q    <= BIST_MODE_CMP;
            golden_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_run) begin
                        state     <= (entries == '0) ? ST_DRAIN : ST_APPLY;
                        rd_idx    <= '0;
                        drain_cnt <= '0;
                        mode_q    <= mode;
                        golden_q  <= golden_sig;
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        rd_idx <= rd_idx + AW'(1);
                        if (last_apply) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (drain_end) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stimulus register holds its last value between runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_stim <= '0;
        end else if (state == ST_APPLY && !abort) begin
            dut_stim <= rd_word[STIM_W-1:0];
        end
    end

    // Pipeline valid bits; emptied on abort and whenever no run is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
        end else if (abort || !busy) begin
            pipe_vld <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
            pipe_vld[0] <= (state == ST_APPLY);
        end
    end

    // Pipeline payload travels alongside the valid bits without a reset
    always_ff @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_idx[i] <= pipe_idx[i-1];
            pipe_exp[i] <= pipe_exp[i-1];
        end
        pipe_idx[0] <= rd_idx;
        pipe_exp[0] <= rd_word[VW-1:STIM_W];
    end

    // Compare-mode bookkeeping and the pass verdict taken when entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else if (start_run) begin
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else if (busy && abort) begin
            pass <= 1'b0;
        end else begin
            if (sample_v && mode_q == BIST_MODE_CMP && mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + (AW+1)'(1);
                end
                if (err_count == '0) begin
                    first_fail <= pipe_idx[LAT-1];
                end
            end
            if (drain_end) begin
                pass <= (mode_q == BIST_MODE_SIG) ? (signature == golden_q)
                                                  : (err_count == '0);
            end
        end
    end

    bist_misr #(
        .RESP_W (RESP_W),
        .TAPS   (TAPS)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_run),
        .enable  (sample_v && mode_q == BIST_MODE_SIG),
        .data_in (dut_resp),
        .sig_out (signature)
    );

endmodule
